pi1_rstseq: RTL



---
 rtl/pi1_rstseq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pi1_rstseq.sv
// Staged reset/power sequencer: releases STAGECOUNT reset outputs in order and
// decodes the devtbl software reset pair into cold, warm and power-off actions.
//
// state   | meaning
// HOLD    | waiting for lock, hold_i low and no warm request; counter reloaded
// COUNT   | counting down the release delay of the current stage
// WAITRDY | delay expired, waiting for ready_i of the current stage
// RUN     | all stages released
// COLD    | driving the coldrst_o pulse
// OFF     | power-off latched; only rst_i leaves
module pi1_rstseq #(
  parameter int                    STAGECOUNT  = 3,
  parameter int                    STAGECYCLES = 65535,
  parameter logic [STAGECOUNT-1:0] WARMMASK    = {STAGECOUNT{1'b1}},
  parameter int                    COLDPULSE   = 16,
  parameter int                    TIMEOUT     = 1048575
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lock_i,
  input  logic                  hold_i,
  input  logic [1:0]            swrst_i,
  input  logic [STAGECOUNT-1:0] ready_i,
  output logic [STAGECOUNT-1:0] rst_o,
  output logic                  coldrst_o,
  output logic                  pwroff_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(STAGECYCLES + 1);
  localparam int SW = (STAGECOUNT > 1) ? $clog2(STAGECOUNT) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = $clog2(COLDPULSE + 1);

  localparam logic [CW-1:0]         CNT_LOAD   = CW'(STAGECYCLES);
  localparam logic [SW-1:0]         LAST_STAGE = SW'(STAGECOUNT - 1);
  localparam logic [TW-1:0]         TO_MAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0]         TO_PRE     = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0]         PULSE_LOAD = PW'(COLDPULSE - 1);
  localparam logic [STAGECOUNT-1:0] ALL_ONES   = '1;

  typedef enum logic [2:0] {
    S_HOLD, S_COUNT, S_WAITRDY, S_RUN, S_COLD, S_OFF
  } state_t;

  state_t                  state_q, state_n;
  logic [SW-1:0]           stage_q, stage_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [TW-1:0]           tocnt_q, tocnt_n;
  logic [PW-1:0]           coldcnt_q, coldcnt_n;
  logic [STAGECOUNT-1:0]   rst_q, rst_n;
  logic                    coldrst_q, coldrst_n;
  logic                    pwroff_q, pwroff_n;
  logic                    err_q, err_n;
  logic                    swblk_q, swblk_n;
  logic                    swrst_ign, req_off, req_cold, req_warm, adv;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_HOLD;
      stage_q   <= '0;
      cnt_q     <= CNT_LOAD;
      tocnt_q   <= '0;
      coldcnt_q <= '0;
      rst_q     <= ALL_ONES;
      coldrst_q <= 1'b0;
      pwroff_q  <= 1'b0;
      err_q     <= 1'b0;
      swblk_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      stage_q   <= stage_n;
      cnt_q     <= cnt_n;
      tocnt_q   <= tocnt_n;
      coldcnt_q <= coldcnt_n;
      rst_q     <= rst_n;
      coldrst_q <= coldrst_n;
      pwroff_q  <= pwroff_n;
      err_q     <= err_n;
      swblk_q   <= swblk_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    stage_n   = stage_q;
    cnt_n     = cnt_q;
    tocnt_n   = tocnt_q;
    coldcnt_n = coldcnt_q;
    rst_n     = rst_q;
    coldrst_n = coldrst_q;
    pwroff_n  = pwroff_q;
    err_n     = err_q;
    adv       = 1'b0;

    // After a cold reset the request pair must pass through 2'b00 before it counts again
    swrst_ign = swblk_q && (swrst_i != 2'b00);
    swblk_n   = swrst_ign;
    req_off   = !swrst_ign && (swrst_i == 2'b01);
    req_cold  = !swrst_ign && (swrst_i == 2'b11);
    req_warm  = hold_i || (!swrst_ign && (swrst_i == 2'b10));

    if (state_q == S_OFF) begin
      swblk_n = swblk_q;
    end else if (!lock_i) begin
      state_n   = S_HOLD;
      rst_n     = ALL_ONES;
      tocnt_n   = '0;
      coldrst_n = 1'b0;
      if (req_off) pwroff_n = 1'b1;
    end else if (req_off) begin
      state_n   = S_OFF;
      rst_n     = ALL_ONES;
      coldrst_n = 1'b0;
      pwroff_n  = 1'b1;
    end else if (req_cold) begin
      state_n   = S_COLD;
      rst_n     = ALL_ONES;
      tocnt_n   = '0;
      coldrst_n = 1'b1;
      coldcnt_n = PULSE_LOAD;
      swblk_n   = 1'b1;
    end else if (state_q == S_COLD) begin
      if (coldcnt_q == '0) begin
        coldrst_n = 1'b0;
        state_n   = S_HOLD;
      end else begin
        coldcnt_n = coldcnt_q - 1'b1;
      end
    end else if (req_warm) begin
      state_n = S_HOLD;
      rst_n   = rst_q | WARMMASK;
      tocnt_n = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          cnt_n   = CNT_LOAD;
          stage_n = '0;
          if (!swrst_ign) state_n = S_COUNT;
        end
        S_COUNT: begin
          // A stage left released by a warm reset is stepped over
          if (!rst_q[stage_q]) begin
            adv = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_n = cnt_q - 1'b1;
          end else if (ready_i[stage_q]) begin
            rst_n[stage_q] = 1'b0;
            adv            = 1'b1;
          end else begin
            state_n = S_WAITRDY;
          end
        end
        S_WAITRDY: begin
          if (ready_i[stage_q]) begin
            rst_n[stage_q] = 1'b0;
            tocnt_n        = '0;
            adv            = 1'b1;
          end else if (tocnt_q != TO_MAX) begin
            tocnt_n = tocnt_q + 1'b1;
            if (tocnt_q == TO_PRE) err_n = 1'b1;
          end
        end
        default: ;
      endcase

      if (adv) begin
        cnt_n = CNT_LOAD;
        if (stage_q == LAST_STAGE) begin
          state_n = S_RUN;
        end else begin
          stage_n = stage_q + 1'b1;
          state_n = S_COUNT;
        end
      end
    end
  end

  assign rst_o     = rst_q;
  assign coldrst_o = coldrst_q;
  assign pwroff_o  = pwroff_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != S_RUN);

endmodule
